// File: rtl/ibex_fp_pkg.sv
// Shared FPU types: opcode enum, writeback sequencer states and fflags bit positions.
package ibex_fp_pkg;

   typedef enum logic [4:0] {
      FPU_NOP,
      FPU_ADD,
      FPU_SUB,
      FPU_MUL,
      FPU_DIV,
      FPU_SQRT,
      FPU_MADD,
      FPU_NMADD,
      FPU_MSUB,
      FPU_NMSUB,
      FPU_SGNJ,
      FPU_SGNJN,
      FPU_SGNJX,
      FPU_MIN,
      FPU_MAX,
      FPU_CMP_EQ,
      FPU_CMP_LT,
      FPU_CMP_LE,
      FPU_FLOAT2INT,
      FPU_FLOAT2INT_U,
      FPU_INT2FLOAT,
      FPU_INT2FLOAT_U,
      FPU_MOVE_FLOAT2INT,
      FPU_MOVE_INT2FLOAT,
      FPU_CLASS
   } fpu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      WB
   } fpu_wb_state_e;

   // Bit positions inside fflags {NV,DZ,OF,UF,NX}
   localparam int unsigned FFLAG_NV = 4;
   localparam int unsigned FFLAG_DZ = 3;
   localparam int unsigned FFLAG_OF = 2;
   localparam int unsigned FFLAG_UF = 1;
   localparam int unsigned FFLAG_NX = 0;

   function automatic logic fpu_op_is_int_dest(input fpu_op_e op);
      logic res;
      case (op)
         FPU_FLOAT2INT, FPU_FLOAT2INT_U, FPU_MOVE_FLOAT2INT,
         FPU_CMP_EQ, FPU_CMP_LT, FPU_CMP_LE, FPU_CLASS: res = 1'b1;
         default:                                       res = 1'b0;
      endcase
      return res;
   endfunction

   // Sign injection, moves and classify never raise exceptions.
   function automatic logic fpu_op_sets_flags(input fpu_op_e op);
      logic res;
      case (op)
         FPU_SGNJ, FPU_SGNJN, FPU_SGNJX,
         FPU_MOVE_FLOAT2INT, FPU_MOVE_INT2FLOAT, FPU_CLASS: res = 1'b0;
         default:                                          res = 1'b1;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ibex_fpu_wb_ctrl_fflags_acc.sv
// Sticky RISC-V exception flags fed from the DesignWare status word of the active unit.
module ibex_fpu_fflags_acc
   import ibex_fp_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       capture_i,
   input  logic [7:0] status_i,
   input  logic       clr_i,
   output logic [4:0] fflags_o
);

   logic [4:0] mapped;

   always_comb begin
      mapped           = '0;
      mapped[FFLAG_NV] = status_i[2];
      mapped[FFLAG_DZ] = status_i[7];
      mapped[FFLAG_OF] = status_i[4];
      mapped[FFLAG_UF] = status_i[3];
      mapped[FFLAG_NX] = status_i[5];
   end

   // A clear coinciding with a capture keeps only the new flags.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         fflags_o <= '0;
      end else if (capture_i) begin
         fflags_o <= (clr_i ? 5'b0 : fflags_o) | mapped;
      end else if (clr_i) begin
         fflags_o <= '0;
      end
   end

endmodule

// File: rtl/ibex_fpu_wb_ctrl.sv
// Issue/writeback sequencer for the combinational FPU datapath.
// Define FPU_FFLAGS_EN to build the sticky exception flag accumulator.
module ibex_fpu_wb_ctrl
   import ibex_fp_pkg::*;
#(
   parameter int unsigned DIV_LATENCY  = 4,
   parameter int unsigned SQRT_LATENCY = 4,
   parameter int unsigned MAC_LATENCY  = 2,
   parameter int unsigned BASE_LATENCY = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  fpu_op_e     req_op_i,
   input  logic [4:0]  req_rd_i,
   input  logic [2:0]  req_rnd_i,
   input  logic        flush_i,
   output fpu_op_e     fpu_op_o,
   output logic [2:0]  fpu_rnd_o,
   input  logic [31:0] fpu_wdata_i,
   input  logic [7:0]  fpu_status_i,
   output logic        wb_valid_o,
   input  logic        wb_ready_i,
   output logic        wb_fp_we_o,
   output logic        wb_int_we_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_data_o,
   input  logic        fflags_clr_i,
   output logic [4:0]  fflags_o,
   output logic        busy_o
);

   localparam int unsigned MaxLat01 = (DIV_LATENCY > SQRT_LATENCY) ? DIV_LATENCY : SQRT_LATENCY;
   localparam int unsigned MaxLat23 = (MAC_LATENCY > BASE_LATENCY) ? MAC_LATENCY : BASE_LATENCY;
   localparam int unsigned MaxLat   = (MaxLat01 > MaxLat23) ? MaxLat01 : MaxLat23;
   localparam int unsigned CntW     = (MaxLat > 1) ? $clog2(MaxLat) : 1;

   function automatic logic [CntW-1:0] latency_m1(input fpu_op_e op);
      int unsigned lat;
      case (op)
         FPU_DIV:                                lat = DIV_LATENCY;
         FPU_SQRT:                               lat = SQRT_LATENCY;
         FPU_MADD, FPU_NMADD, FPU_MSUB, FPU_NMSUB: lat = MAC_LATENCY;
         default:                                lat = BASE_LATENCY;
      endcase
      return CntW'(lat - 1);
   endfunction

   fpu_wb_state_e   state_q;
   fpu_op_e         op_q;
   logic [4:0]      rd_q;
   logic [CntW-1:0] cnt_q;

   assign req_ready_o = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         op_q        <= FPU_NOP;
         rd_q        <= '0;
         cnt_q       <= '0;
         fpu_op_o    <= FPU_NOP;
         fpu_rnd_o   <= '0;
         wb_valid_o  <= 1'b0;
         wb_fp_we_o  <= 1'b0;
         wb_int_we_o <= 1'b0;
         wb_rd_o     <= '0;
         wb_data_o   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // NOP is accepted but never leaves IDLE; flush blocks the accept.
               if (!flush_i && req_valid_i && (req_op_i != FPU_NOP)) begin
                  op_q      <= req_op_i;
                  rd_q      <= req_rd_i;
                  cnt_q     <= latency_m1(req_op_i);
                  fpu_op_o  <= req_op_i;
                  fpu_rnd_o <= req_rnd_i;
                  state_q   <= EXEC;
               end
            end
            EXEC: begin
               if (flush_i) begin
                  fpu_op_o  <= FPU_NOP;
                  fpu_rnd_o <= '0;
                  state_q   <= IDLE;
               end else if (cnt_q == '0) begin
                  wb_data_o   <= fpu_wdata_i;
                  wb_rd_o     <= rd_q;
                  wb_int_we_o <= fpu_op_is_int_dest(op_q);
                  wb_fp_we_o  <= !fpu_op_is_int_dest(op_q);
                  wb_valid_o  <= 1'b1;
                  fpu_op_o    <= FPU_NOP;
                  fpu_rnd_o   <= '0;
                  state_q     <= WB;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            WB: begin
               if (flush_i || wb_ready_i) begin
                  wb_valid_o  <= 1'b0;
                  wb_fp_we_o  <= 1'b0;
                  wb_int_we_o <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef FPU_FFLAGS_EN
   logic flag_capture;
   assign flag_capture = (state_q == EXEC) && (cnt_q == '0) && !flush_i &&
                         fpu_op_sets_flags(op_q);

   ibex_fpu_fflags_acc u_fflags (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .capture_i (flag_capture),
      .status_i  (fpu_status_i),
      .clr_i     (fflags_clr_i),
      .fflags_o  (fflags_o)
   );
`else
   logic unused_flag_inputs;
   assign unused_flag_inputs = ^{fpu_status_i, fflags_clr_i};
   assign fflags_o = '0;
`endif

endmodule
